// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 1 Hz prescaler plus a 24-hour HH:MM:SS count held as six
// BCD digits, with a front-panel time-set mode (seconds cleared, hour/minute
// increment buttons). All outputs come straight from registers.
module bcd_time_counter #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_mode,
    input  logic       inc_hr,
    input  logic       inc_min,
    output logic [1:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       sec_pulse,
    output logic       day_wrap
);

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    logic [31:0] presc_q, presc_d;
    logic [1:0]  hr_tens_q, hr_tens_d;
    logic [3:0]  hr_ones_q, hr_ones_d;
    logic [2:0]  min_tens_q, min_tens_d;
    logic [3:0]  min_ones_q, min_ones_d;
    logic [2:0]  sec_tens_q, sec_tens_d;
    logic [3:0]  sec_ones_q, sec_ones_d;
    logic        sec_pulse_q, sec_pulse_d;
    logic        day_wrap_q, day_wrap_d;

    // Incremented candidates for each field, shared by run and set paths.
    logic [1:0]  hr_tens_inc;
    logic [3:0]  hr_ones_inc;
    logic [2:0]  min_tens_inc;
    logic [3:0]  min_ones_inc;
    logic [2:0]  sec_tens_inc;
    logic [3:0]  sec_ones_inc;

    logic        tick;
    logic        sec_at_max;
    logic        min_at_max;
    logic        hr_at_max;

    assign tick       = !set_mode && (presc_q == TICK_LAST);
    assign sec_at_max = (sec_tens_q == 3'd5) && (sec_ones_q == 4'd9);
    assign min_at_max = (min_tens_q == 3'd5) && (min_ones_q == 4'd9);
    assign hr_at_max  = (hr_tens_q == 2'd2) && (hr_ones_q == 4'd3);

    // Per-field "+1 with BCD wrap": seconds/minutes 59->00, hours 23->00.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sec_ones_inc = sec_ones_q + 4'd1;
        sec_tens_inc = sec_tens_q;
        if (sec_ones_q == 4'd9) begin
            sec_ones_inc = 4'd0;
            sec_tens_inc = (sec_tens_q == 3'd5) ? 3'd0 : sec_tens_q + 3'd1;
        end

        min_ones_inc = min_ones_q + 4'd1;
        min_tens_inc = min_tens_q;
        if (min_ones_q == 4'd9) begin
            min_ones_inc = 4'd0;
            min_tens_inc = (min_tens_q == 3'd5) ? 3'd0 : min_tens_q + 3'd1;
        end

        hr_ones_inc = hr_ones_q + 4'd1;
        hr_tens_inc = hr_tens_q;
        if (hr_at_max) begin
            hr_ones_inc = 4'd0;
            hr_tens_inc = 2'd0;
        end else if (hr_ones_q == 4'd9) begin
            hr_ones_inc = 4'd0;
            hr_tens_inc = hr_tens_q + 2'd1;
        end
    end

    // Next-state selection: set mode edits fields directly, run mode ripples
    // the tick through seconds -> minutes -> hours.
    always_comb begin
        presc_d     = presc_q + 32'd1;
        hr_tens_d   = hr_tens_q;
        hr_ones_d   = hr_ones_q;
        min_tens_d  = min_tens_q;
        min_ones_d  = min_ones_q;
        sec_tens_d  = sec_tens_q;
        sec_ones_d  = sec_ones_q;
        sec_pulse_d = tick;
        day_wrap_d  = tick && sec_at_max && min_at_max && hr_at_max;

        if (set_mode) begin
            presc_d    = 32'd0;
            sec_tens_d = 3'd0;
            sec_ones_d = 4'd0;
            // Minute increments never carry into hours while setting.
            if (inc_min) begin
                min_tens_d = min_tens_inc;
                min_ones_d = min_ones_inc;
            end
            if (inc_hr) begin
                hr_tens_d = hr_tens_inc;
                hr_ones_d = hr_ones_inc;
            end
        end else if (tick) begin
            presc_d    = 32'd0;
            sec_tens_d = sec_tens_inc;
            sec_ones_d = sec_ones_inc;
            if (sec_at_max) begin
                min_tens_d = min_tens_inc;
                min_ones_d = min_ones_inc;
                if (min_at_max) begin
                    hr_tens_d = hr_tens_inc;
                    hr_ones_d = hr_ones_inc;
                end
            end
        end
    end

    // State registers; reset wins over set mode and increment pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            presc_q     <= 32'd0;
            hr_tens_q   <= 2'd0;
            hr_ones_q   <= 4'd0;
            min_tens_q  <= 3'd0;
            min_ones_q  <= 4'd0;
            sec_tens_q  <= 3'd0;
            sec_ones_q  <= 4'd0;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            hr_tens_q   <= hr_tens_d;
            hr_ones_q   <= hr_ones_d;
            min_tens_q  <= min_tens_d;
            min_ones_q  <= min_ones_d;
            sec_tens_q  <= sec_tens_d;
            sec_ones_q  <= sec_ones_d;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q  <= day_wrap_d;
        end
    end

    assign hr_tens   = hr_tens_q;
    assign hr_ones   = hr_ones_q;
    assign min_tens  = min_tens_q;
    assign min_ones  = min_ones_q;
    assign sec_tens  = sec_tens_q;
    assign sec_ones  = sec_ones_q;
    assign sec_pulse = sec_pulse_q;
    assign day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter with TICK_DIV=4. Time is compared as a
// 24-bit value 0xHHMMSS so expected values read like the clock face.
module tb_bcd_time_counter;

    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       set_mode;
    logic       inc_hr;
    logic       inc_min;
    logic [1:0] hr_tens;
    logic [3:0] hr_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       sec_pulse;
    logic       day_wrap;

    int tests_run    = 0;
    int tests_failed = 0;

    bcd_time_counter #(.TICK_DIV(TICK)) dut (
        .clk       (clk),
        .reset     (reset),
        .set_mode  (set_mode),
        .inc_hr    (inc_hr),
        .inc_min   (inc_min),
        .hr_tens   (hr_tens),
        .hr_ones   (hr_ones),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .sec_pulse (sec_pulse),
        .day_wrap  (day_wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [23:0] now_time();
        return {2'b00, hr_tens, hr_ones, 1'b0, min_tens, min_ones,
                1'b0, sec_tens, sec_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run until n sec_pulse cycles have been seen (bounded); ends in the
    // cycle of the n-th pulse.
    task automatic wait_pulses(input int n, input string tag);
        int seen   = 0;
        int budget = (n + 2) * TICK;
        while (seen < n && budget > 0) begin
            step();
            budget--;
            if (sec_pulse) seen++;
        end
        check({tag, "_pulses"}, seen, n);
    endtask

    // Reset, then enter set mode and key in hh:mm with held increment pulses.
    // Leaves set_mode=1.
    task automatic set_time(input int hh, input int mm, input logic [23:0] exp,
                            input string tag);
        reset = 1'b1;
        step();
        reset    = 1'b0;
        set_mode = 1'b1;
        inc_hr   = 1'b1;
        repeat (hh) step();
        inc_hr  = 1'b0;
        inc_min = 1'b1;
        repeat (mm) step();
        inc_min = 1'b0;
        check({tag, "_set"}, now_time(), exp);
    endtask

    initial begin
        int cnt;
        reset    = 1'b1;
        set_mode = 1'b0;
        inc_hr   = 1'b0;
        inc_min  = 1'b0;
        repeat (3) step();

        // Reset release and first tick: cycle 0 is the first with reset low.
        reset = 1'b0;
        check("rst_time", now_time(), 24'h000000);
        check("rst_pulse", sec_pulse, 1'b0);
        check("rst_wrap", day_wrap, 1'b0);
        cnt = 0;
        repeat (TICK - 1) begin
            step();
            cnt += int'(sec_pulse);
        end
        check("first_early_pulses", cnt, 0);
        step();
        check("first_pulse", sec_pulse, 1'b1);
        check("first_time", now_time(), 24'h000001);
        cnt = 0;
        repeat (TICK - 1) begin
            step();
            cnt += int'(sec_pulse);
        end
        check("gap_pulses", cnt, 0);
        step();
        check("second_pulse", sec_pulse, 1'b1);
        check("second_time", now_time(), 24'h000002);

        // Carry chain through minutes and hours.
        set_time(0, 0, 24'h000000, "c0");
        set_mode = 1'b0;
        wait_pulses(60, "c0");
        check("c0_time", now_time(), 24'h000100);

        set_time(9, 59, 24'h095900, "c1");
        set_mode = 1'b0;
        wait_pulses(60, "c1");
        check("c1_time", now_time(), 24'h100000);

        set_time(19, 59, 24'h195900, "c2");
        set_mode = 1'b0;
        wait_pulses(60, "c2");
        check("c2_time", now_time(), 24'h200000);

        // Day rollover.
        set_time(23, 59, 24'h235900, "day");
        set_mode = 1'b0;
        wait_pulses(59, "day59");
        check("day59_time", now_time(), 24'h235959);
        check("day59_wrap", day_wrap, 1'b0);
        wait_pulses(1, "day60");
        check("day_time", now_time(), 24'h000000);
        check("day_wrap", day_wrap, 1'b1);
        check("day_pulse", sec_pulse, 1'b1);
        step();
        check("day_wrap_clear", day_wrap, 1'b0);
        check("day_time_after", now_time(), 24'h000000);

        // Set mode entered in the very cycle the tick would fire.
        set_time(12, 34, 24'h123400, "sm");
        set_mode = 1'b0;
        wait_pulses(27, "sm");
        check("sm_run_time", now_time(), 24'h123427);
        repeat (TICK - 1) step();
        set_mode = 1'b1;
        step();
        check("sm_sec_clear", now_time(), 24'h123400);
        check("sm_tick_supp", sec_pulse, 1'b0);
        cnt = 0;
        repeat (20) begin
            step();
            cnt += int'(sec_pulse);
        end
        check("sm_no_pulses", cnt, 0);
        inc_min = 1'b1;
        repeat (26) step();
        inc_min = 1'b0;
        check("sm_min_wrap", now_time(), 24'h120000);
        inc_hr = 1'b1;
        repeat (12) step();
        inc_hr = 1'b0;
        check("sm_hr_wrap", now_time(), 24'h000000);
        inc_hr  = 1'b1;
        inc_min = 1'b1;
        step();
        inc_hr  = 1'b0;
        inc_min = 1'b0;
        check("sm_both", now_time(), 24'h010100);

        // Leave set mode with increments held: they must be ignored, and
        // the first pulse arrives TICK cycles later.
        set_mode = 1'b0;
        inc_hr   = 1'b1;
        inc_min  = 1'b1;
        step();
        check("run_inc_ignored", now_time(), 24'h010100);
        cnt = int'(sec_pulse);
        step();
        inc_hr  = 1'b0;
        inc_min = 1'b0;
        cnt += int'(sec_pulse);
        step();
        cnt += int'(sec_pulse);
        check("resume_early_pulses", cnt, 0);
        check("run_inc_ignored2", now_time(), 24'h010100);
        step();
        check("resume_pulse", sec_pulse, 1'b1);
        check("resume_time", now_time(), 24'h010101);

        // Reset mid-count overrides set_mode and inc_hr.
        set_time(17, 45, 24'h174500, "mr");
        set_mode = 1'b0;
        wait_pulses(33, "mr");
        check("mr_run_time", now_time(), 24'h174533);
        reset    = 1'b1;
        set_mode = 1'b1;
        inc_hr   = 1'b1;
        step();
        check("mr_time", now_time(), 24'h000000);
        check("mr_pulse", sec_pulse, 1'b0);
        check("mr_wrap", day_wrap, 1'b0);
        reset    = 1'b0;
        set_mode = 1'b0;
        inc_hr   = 1'b0;
        cnt = 0;
        repeat (TICK - 1) begin
            step();
            cnt += int'(sec_pulse);
        end
        check("mr_early_pulses", cnt, 0);
        step();
        check("mr_first_pulse", sec_pulse, 1'b1);
        check("mr_first_time", now_time(), 24'h000001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
